// File: rtl/latch_bank.sv
// latch_bank: NCH independent WIDTH-bit hold registers with a freeze handshake.
// Define LATCH_BANK_CHG_EN to build the per-channel CHG change-detect outputs.
module latch_bank #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NCH-1:0]       G,
    input  logic [NCH*WIDTH-1:0] D,
    input  logic                 MODE,
    input  logic                 FRZ_REQ,
    output logic                 FRZ_ACK,
    output logic [NCH*WIDTH-1:0] Q,
    output logic [NCH-1:0]       CHG
);

    typedef enum logic [1:0] {
        RUN,
        FROZEN,
        RELEASE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 run_ok;
    logic                 ack;
    logic [NCH-1:0]       gp;
    logic [NCH-1:0]       load;
    logic [NCH*WIDTH-1:0] q;

    always_comb begin
        state_nxt = state;
        run_ok    = 1'b0;
        unique case (state)
            RUN: begin
                if (FRZ_REQ) state_nxt = FROZEN;
                else         run_ok    = 1'b1;
            end
            FROZEN: begin
                if (!FRZ_REQ) state_nxt = RELEASE;
            end
            RELEASE: state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Edge mode compares against last cycle's gate, so edges seen while frozen are consumed.
    always_comb begin
        load = '0;
        for (int i = 0; i < NCH; i++) begin
            load[i] = run_ok & G[i] & (~MODE | ~gp[i]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= RUN;
            ack   <= 1'b0;
            gp    <= '0;
        end else begin
            state <= state_nxt;
            ack   <= (state_nxt == FROZEN);
            gp    <= G;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (load[i]) q[i*WIDTH +: WIDTH] <= D[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef LATCH_BANK_CHG_EN
    logic [NCH-1:0] diff;
    logic [NCH-1:0] chg;

    always_comb begin
        diff = '0;
        for (int i = 0; i < NCH; i++) begin
            diff[i] = load[i] & (D[i*WIDTH +: WIDTH] != q[i*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) chg <= '0;
        else        chg <= diff;
    end

    assign CHG = chg;
`else
    assign CHG = '0;
`endif

    assign Q       = q;
    assign FRZ_ACK = ack;

endmodule

// File: tb/tb_latch_bank.sv
// Self-checking bench for latch_bank: directed vector table, freeze/reset
// sequences and randomized traffic against a behavioural model.
module tb_latch_bank;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;

`ifdef LATCH_BANK_CHG_EN
    localparam logic [NCH-1:0] CHG_MASK = '1;
`else
    localparam logic [NCH-1:0] CHG_MASK = '0;
`endif

    logic                 CLK;
    logic                 RST_N;
    logic [NCH-1:0]       G;
    logic [NCH*WIDTH-1:0] D;
    logic                 MODE;
    logic                 FRZ_REQ;
    logic                 FRZ_ACK;
    logic [NCH*WIDTH-1:0] Q;
    logic [NCH-1:0]       CHG;

    latch_bank #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .G       (G),
        .D       (D),
        .MODE    (MODE),
        .FRZ_REQ (FRZ_REQ),
        .FRZ_ACK (FRZ_ACK),
        .Q       (Q),
        .CHG     (CHG)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks   = 0;
    int failures = 0;

    // Model: per-channel held values, previous gate, and the freeze handshake as
    // "acknowledged" plus a one-edge "cooling down" flag after release.
    logic [WIDTH-1:0] mq [NCH];
    logic [NCH-1:0]   mgp;
    logic [NCH-1:0]   mchg;
    bit               m_ack;
    bit               m_cool;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) mq[i] = '0;
        mgp    = '0;
        mchg   = '0;
        m_ack  = 0;
        m_cool = 0;
    endfunction

    function automatic logic [NCH*WIDTH-1:0] model_q();
        logic [NCH*WIDTH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*WIDTH +: WIDTH] = mq[i];
        return v;
    endfunction

    function automatic void model_edge();
        bit allow;
        allow = !FRZ_REQ && !m_ack && !m_cool;
        for (int i = 0; i < NCH; i++) begin
            bit               ld;
            logic [WIDTH-1:0] nv;
            nv = D[i*WIDTH +: WIDTH];
            ld = allow && G[i] && (!MODE || !mgp[i]);
            mchg[i] = ld && (nv != mq[i]);
            if (ld) mq[i] = nv;
        end
        if (m_cool) begin
            m_cool = 0;
            m_ack  = 0;
        end else if (m_ack) begin
            if (!FRZ_REQ) begin
                m_ack  = 0;
                m_cool = 1;
            end
        end else begin
            m_ack = FRZ_REQ;
        end
        mgp = G;
    endfunction

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        chk("model_q", Q, model_q());
        chk("model_chg", CHG, mchg & CHG_MASK);
        chk("model_ack", FRZ_ACK, m_ack);
    endtask

    typedef struct {
        logic [NCH-1:0]       g;
        logic [NCH*WIDTH-1:0] d;
        logic                 mode;
        logic [NCH*WIDTH-1:0] q;
        logic [NCH-1:0]       chg;
    } vec_t;

    vec_t tbl [12];

    logic [NCH*WIDTH-1:0] snap;
    logic [WIDTH-1:0]     ch3;

    initial begin
        tbl[0]  = '{4'b0001, 32'h0000_00A5, 1'b0, 32'h0000_00A5, 4'b0001};
        tbl[1]  = '{4'b0001, 32'h0000_003C, 1'b0, 32'h0000_003C, 4'b0001};
        tbl[2]  = '{4'b0000, 32'h0000_00FF, 1'b0, 32'h0000_003C, 4'b0000};
        tbl[3]  = '{4'b0010, 32'h0000_0A00, 1'b1, 32'h0000_0A3C, 4'b0010};
        tbl[4]  = '{4'b0010, 32'h0000_0B00, 1'b1, 32'h0000_0A3C, 4'b0000};
        tbl[5]  = '{4'b0010, 32'h0000_0C00, 1'b1, 32'h0000_0A3C, 4'b0000};
        tbl[6]  = '{4'b0010, 32'h0000_0D00, 1'b1, 32'h0000_0A3C, 4'b0000};
        tbl[7]  = '{4'b0010, 32'h0000_0E00, 1'b1, 32'h0000_0A3C, 4'b0000};
        tbl[8]  = '{4'b0000, 32'h0000_0000, 1'b1, 32'h0000_0A3C, 4'b0000};
        tbl[9]  = '{4'b0100, 32'h0055_0000, 1'b0, 32'h0055_0A3C, 4'b0100};
        tbl[10] = '{4'b0100, 32'h0055_0000, 1'b0, 32'h0055_0A3C, 4'b0000};
        tbl[11] = '{4'b0100, 32'h0055_0000, 1'b0, 32'h0055_0A3C, 4'b0000};

        RST_N   = 1'b0;
        G       = '0;
        D       = '0;
        MODE    = 1'b0;
        FRZ_REQ = 1'b0;
        model_reset();
        #12;
        chk("reset_q", Q, '0);
        chk("reset_chg", CHG, '0);
        chk("reset_ack", FRZ_ACK, 1'b0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Directed vectors: transparent, edge capture, identical reload
        for (int i = 0; i < 12; i++) begin
            G    = tbl[i].g;
            D    = tbl[i].d;
            MODE = tbl[i].mode;
            step();
            chk($sformatf("vec%0d_q", i), Q, tbl[i].q);
            chk($sformatf("vec%0d_chg", i), CHG, tbl[i].chg & CHG_MASK);
        end

        // Freeze handshake
        MODE = 1'b0;
        G    = 4'hF;
        D    = $urandom;
        step();
        snap    = Q;
        FRZ_REQ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            D = $urandom;
            step();
            chk("frz_ack_on", FRZ_ACK, 1'b1);
            chk("frz_hold_q", Q, snap);
        end
        FRZ_REQ = 1'b0;
        D = $urandom;
        step();
        chk("frz_exit_ack", FRZ_ACK, 1'b0);
        chk("frz_exit_q", Q, snap);
        D = $urandom;
        step();
        chk("frz_release_q", Q, snap);
        D = 32'h1234_5678;
        step();
        chk("frz_resume_q", Q, 32'h1234_5678);

        // Rising gate edge seen only while frozen is lost
        MODE = 1'b1;
        G    = 4'b0000;
        step();
        ch3     = Q[31:24];
        FRZ_REQ = 1'b1;
        step();
        G = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            D = {8'hC0 + 8'(i), 24'h0};
            step();
        end
        FRZ_REQ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            D = {8'hD0 + 8'(i), 24'h0};
            step();
            chk("lost_edge_q3", Q[31:24], ch3);
        end

        // Async reset while frozen with nonzero Q
        MODE = 1'b0;
        G    = 4'hF;
        D    = 32'hDEAD_BEEF;
        step();
        FRZ_REQ = 1'b1;
        step();
        chk("pre_rst_ack", FRZ_ACK, 1'b1);
        chk("pre_rst_q", Q, 32'hDEAD_BEEF);
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        chk("async_rst_q", Q, '0);
        chk("async_rst_ack", FRZ_ACK, 1'b0);
        chk("async_rst_chg", CHG, '0);

        // Edge mode with gate held high through reset release captures at once
        FRZ_REQ = 1'b0;
        MODE    = 1'b1;
        G       = 4'hF;
        D       = 32'h0102_0304;
        @(negedge CLK);
        RST_N = 1'b1;
        step();
        chk("post_rst_capture", Q, 32'h0102_0304);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            G    = NCH'($urandom);
            D    = $urandom;
            MODE = ($urandom_range(0, 7) == 0) ? ~MODE : MODE;
            if ($urandom_range(0, 5) == 0) FRZ_REQ = ~FRZ_REQ;
            if ($urandom_range(0, 3) == 0) D = Q;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
